// File: rtl/oled_frame_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : oled_frame_sched_if
// Description : Pixel-stream bundle between oled_video, the pixel sources and
//               the frame scheduler. The slave modport is the scheduler's view.
// Revision    : 1.0 - initial release
// ============================================================================
interface oled_frame_sched_if #(
    parameter int C_N_SRC      = 3,
    parameter int C_COLOR_BITS = 16
);
    // Coordinates from oled_video and per-source requests/colours
    logic [6:0]                        x;
    logic [6:0]                        y;
    logic [C_N_SRC-1:0]                req;
    logic [C_N_SRC*C_COLOR_BITS-1:0]   src_color;

    // Scheduler results
    logic [C_COLOR_BITS-1:0]           color;
    logic [C_N_SRC-1:0]                grant;
    logic                              frame_start;
    logic [C_N_SRC-1:0]                frame_done;
    logic [15:0]                       frame_cnt;

    modport master (
        output x, y, req, src_color,
        input  color, grant, frame_start, frame_done, frame_cnt
    );

    modport slave (
        input  x, y, req, src_color,
        output color, grant, frame_start, frame_done, frame_cnt
    );
endinterface
`default_nettype wire

// File: rtl/oled_frame_sched.sv
`default_nettype none
// ============================================================================
// Module      : oled_frame_sched
// Description : Frame-granular round-robin scheduler that hands the OLED pixel
//               stream to one of C_N_SRC sources. Ownership only changes on a
//               frame boundary (transition onto pixel (0,0)), an owner may keep
//               the stream for at most C_MAX_FRAMES consecutive frames while
//               another source waits, and a background colour is shown when
//               nobody requests.
// Revision    : 1.0 - initial release
// ============================================================================
module oled_frame_sched #(
    parameter int                      C_N_SRC      = 3,
    parameter int                      C_COLOR_BITS = 16,
    parameter int                      C_X_SIZE     = 128,
    parameter int                      C_Y_SIZE     = 128,
    parameter int                      C_MAX_FRAMES = 4,
    parameter logic [C_COLOR_BITS-1:0] C_BG_COLOR   = '0
) (
    input  wire logic          clk,
    input  wire logic          resetn,
    oled_frame_sched_if.slave  bus
);

    localparam int PTR_W  = (C_N_SRC > 1) ? $clog2(C_N_SRC) : 1;
    localparam int HOLD_W = $clog2(C_MAX_FRAMES + 1);

    localparam logic [6:0]        C_X_LAST   = 7'(C_X_SIZE - 1);
    localparam logic [6:0]        C_Y_LAST   = 7'(C_Y_SIZE - 1);
    localparam logic [HOLD_W-1:0] C_HOLD_MAX = HOLD_W'(C_MAX_FRAMES);
    localparam logic [HOLD_W-1:0] C_HOLD_ONE = HOLD_W'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_OWN  = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t               state_q, state_d;
    logic [C_N_SRC-1:0]   grant_q, grant_d;
    logic [PTR_W-1:0]     ptr_q,   ptr_d;      // last winner == current owner in OWN
    logic [HOLD_W-1:0]    hold_q,  hold_d;     // frames owned consecutively, saturating
    logic [6:0]           prev_x_q;
    logic [6:0]           prev_y_q;
    logic                 first_q;             // no boundary seen since reset
    logic                 frame_start_q;
    logic [C_N_SRC-1:0]   frame_done_q;
    logic [15:0]          frame_cnt_q;

    // ------------------------------------------------------------------------
    // Frame boundary detection
    // ------------------------------------------------------------------------
    logic in_range;
    logic at_origin;
    logic prev_origin;
    logic boundary;

    // Out-of-range coordinates never disturb the previous-coordinate register,
    // so they can neither create nor mask a boundary.
    assign in_range    = (int'(bus.x) < C_X_SIZE) && (int'(bus.y) < C_Y_SIZE);
    assign at_origin   = (bus.x == 7'd0) && (bus.y == 7'd0);
    assign prev_origin = (prev_x_q == 7'd0) && (prev_y_q == 7'd0);
    // A held (0,0) only fires on its first cycle.
    assign boundary    = in_range && at_origin && !prev_origin;

    // ------------------------------------------------------------------------
    // Arbitration helpers
    // ------------------------------------------------------------------------
    logic other_req;
    logic found;
    int   win;
    int   start;

    assign other_req = |(bus.req & ~grant_q);

    // Circular first-set search: from owner+1 while owning, from the pointer when idle.
    always_comb begin
        found = 1'b0;
        win   = 0;
        start = (state_q == S_OWN) ? ((int'(ptr_q) + 1) % C_N_SRC) : int'(ptr_q);
        for (int k = 0; k < C_N_SRC; k++) begin
            if (!found && bus.req[(start + k) % C_N_SRC]) begin
                found = 1'b1;
                win   = (start + k) % C_N_SRC;
            end
        end
    end

    // Next-state logic; ownership is only re-evaluated on a boundary cycle.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        if (boundary) begin
            if ((state_q == S_OWN) && bus.req[ptr_q] &&
                ((hold_q < C_HOLD_MAX) || !other_req)) begin
                hold_d = (hold_q == C_HOLD_MAX) ? hold_q : (hold_q + C_HOLD_ONE);
            end else if (found) begin
                state_d      = S_OWN;
                grant_d      = '0;
                grant_d[win] = 1'b1;
                ptr_d        = PTR_W'(win);
                hold_d       = C_HOLD_ONE;
            end else begin
                state_d = S_IDLE;
                grant_d = '0;
                hold_d  = '0;
            end
        end
    end

    // Ownership state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    // Previous coordinate; the reset value makes a (0,0) right after reset a boundary.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prev_x_q <= C_X_LAST;
            prev_y_q <= C_Y_LAST;
        end else if (in_range) begin
            prev_x_q <= bus.x;
            prev_y_q <= bus.y;
        end
    end

    // Frame pulses and completed-frame counter, aligned with the new grant.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            first_q       <= 1'b1;
            frame_start_q <= 1'b0;
            frame_done_q  <= '0;
            frame_cnt_q   <= '0;
        end else begin
            frame_start_q <= boundary;
            frame_done_q  <= (boundary && (state_q == S_OWN)) ? grant_q : '0;
            if (boundary) begin
                first_q <= 1'b0;
                // The first boundary after reset only opens a frame.
                if (!first_q) begin
                    frame_cnt_q <= frame_cnt_q + 16'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Colour mux, driven straight from the grant register
    // ------------------------------------------------------------------------
    logic [C_COLOR_BITS-1:0] color_mux;

    // One-hot select of the owner's colour, background while idle.
    always_comb begin
        color_mux = C_BG_COLOR;
        for (int i = 0; i < C_N_SRC; i++) begin
            if (grant_q[i]) begin
                color_mux = bus.src_color[i*C_COLOR_BITS +: C_COLOR_BITS];
            end
        end
    end

    assign bus.color       = color_mux;
    assign bus.grant       = grant_q;
    assign bus.frame_start = frame_start_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.frame_cnt   = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_oled_frame_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_oled_frame_sched
// Description : Self-checking bench for oled_frame_sched. Each boundary driven
//               pushes its expected grant / frame_done / frame_cnt; a monitor
//               pops and compares on every frame_start pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_oled_frame_sched;

    localparam int          N  = 3;
    localparam int          CB = 16;
    localparam logic [15:0] BG = 16'hA5A5;
    localparam logic [15:0] C0 = 16'h1111;
    localparam logic [15:0] C1 = 16'h2222;
    localparam logic [15:0] C2 = 16'h3333;

    logic clk    = 1'b0;
    logic resetn = 1'b0;

    always #5 clk = ~clk;

    oled_frame_sched_if #(.C_N_SRC(N), .C_COLOR_BITS(CB)) bus ();

    oled_frame_sched #(
        .C_N_SRC      (N),
        .C_COLOR_BITS (CB),
        .C_X_SIZE     (128),
        .C_Y_SIZE     (128),
        .C_MAX_FRAMES (4),
        .C_BG_COLOR   (BG)
    ) u_dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct packed {
        logic [2:0]  g;
        logic [2:0]  d;
        logic [15:0] c;
    } exp_t;

    exp_t sb[$];
    int   n_checks  = 0;
    int   n_pass    = 0;
    int   n_starts  = 0;
    int   exp_cnt   = 0;
    bit   first_bnd = 1'b1;

    function automatic logic [15:0] exp_color(input logic [2:0] g);
        case (g)
            3'b001:  return C0;
            3'b010:  return C1;
            3'b100:  return C2;
            default: return BG;
        endcase
    endfunction

    // One pixel cycle: coordinates presented, then the clock edge, then settle.
    task automatic step(input int xv, input int yv);
        bus.x = 7'(xv);
        bus.y = 7'(yv);
        @(posedge clk);
        #1;
    endtask

    // Record what the DUT must report at the boundary about to be driven.
    task automatic push_exp(input logic [2:0] g, input logic [2:0] d);
        if (first_bnd) first_bnd = 1'b0;
        else           exp_cnt++;
        sb.push_back('{g: g, d: d, c: exp_cnt[15:0]});
    endtask

    // A short frame: boundary at (0,0) followed by len-1 pixels on line 0.
    task automatic frame(input logic [2:0] g, input logic [2:0] d, input int len);
        push_exp(g, d);
        step(0, 0);
        for (int k = 1; k < len; k++) step(k, 0);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        bus.x  = 7'd9;
        bus.y  = 7'd9;
        repeat (3) @(posedge clk);
        #1;
        sb.delete();
        exp_cnt   = 0;
        first_bnd = 1'b1;
        resetn    = 1'b1;
        step(9, 9);
    endtask

    // Compares every frame_start against the scoreboard; frame_done may only pulse with it.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.frame_start === 1'b1) begin
                n_starts++;
                n_checks++;
                if (sb.size() == 0) begin
                    $display("FAIL start_unexpected: frame_start=1 at %0t, expected no boundary", $time);
                end else begin
                    n_pass++;
                    e = sb.pop_front();
                    n_checks++;
                    if (bus.grant !== e.g) $display("FAIL sb_grant: got %b expected %b", bus.grant, e.g);
                    else n_pass++;
                    n_checks++;
                    if (bus.frame_done !== e.d) $display("FAIL sb_frame_done: got %b expected %b", bus.frame_done, e.d);
                    else n_pass++;
                    n_checks++;
                    if (bus.frame_cnt !== e.c) $display("FAIL sb_frame_cnt: got %0d expected %0d", bus.frame_cnt, e.c);
                    else n_pass++;
                    n_checks++;
                    if (bus.color !== exp_color(e.g)) $display("FAIL sb_color: got %h expected %h", bus.color, exp_color(e.g));
                    else n_pass++;
                end
            end else begin
                n_checks++;
                if (bus.frame_done !== 3'b000) $display("FAIL done_without_start: got %b expected 000", bus.frame_done);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        bus.req = 3'b000;
        n_checks++; if (bus.grant !== 3'b000) $display("FAIL rst_grant: got %b expected 000", bus.grant); else n_pass++;
        n_checks++; if (bus.color !== BG) $display("FAIL rst_color: got %h expected %h", bus.color, BG); else n_pass++;
        n_checks++; if (bus.frame_start !== 1'b0) $display("FAIL rst_start: got %b expected 0", bus.frame_start); else n_pass++;
        n_checks++; if (bus.frame_done !== 3'b000) $display("FAIL rst_done: got %b expected 000", bus.frame_done); else n_pass++;
        n_checks++; if (bus.frame_cnt !== 16'd0) $display("FAIL rst_cnt: got %0d expected 0", bus.frame_cnt); else n_pass++;
        for (int f = 0; f < 3; f++) frame(3'b000, 3'b000, 20);
        step(1, 1);
        n_checks++; if (bus.frame_cnt !== 16'd2) $display("FAIL idle_cnt: got %0d expected 2", bus.frame_cnt); else n_pass++;
        n_checks++; if (bus.grant !== 3'b000) $display("FAIL idle_grant: got %b expected 000", bus.grant); else n_pass++;
        n_checks++; if (bus.color !== BG) $display("FAIL idle_color: got %h expected %h", bus.color, BG); else n_pass++;
        n_checks++; if (sb.size() != 0) $display("FAIL idle_sb_left: got %0d pending expected 0", sb.size()); else n_pass++;
    endtask

    task automatic test_late_req();
        do_reset();
        bus.req = 3'b000;
        frame(3'b000, 3'b000, 4);
        step(5, 1);
        step(5, 40);
        bus.req = 3'b010;
        repeat (5) step(6, 40);
        n_checks++; if (bus.grant !== 3'b000) $display("FAIL late_mid_grant: got %b expected 000", bus.grant); else n_pass++;
        n_checks++; if (bus.color !== BG) $display("FAIL late_mid_color: got %h expected %h", bus.color, BG); else n_pass++;
        step(127, 127);
        n_checks++; if (bus.grant !== 3'b000) $display("FAIL late_pre_grant: got %b expected 000", bus.grant); else n_pass++;
        push_exp(3'b010, 3'b000);
        step(0, 0);
        n_checks++; if (bus.grant !== 3'b010) $display("FAIL late_post_grant: got %b expected 010", bus.grant); else n_pass++;
        n_checks++; if (bus.color !== C1) $display("FAIL late_post_color: got %h expected %h", bus.color, C1); else n_pass++;
        step(1, 0);
        frame(3'b010, 3'b010, 4);
        step(1, 1);
        n_checks++; if (sb.size() != 0) $display("FAIL late_sb_left: got %0d pending expected 0", sb.size()); else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [2:0] one;
        logic [2:0] g;
        logic [2:0] d;
        one = 3'b001;
        do_reset();
        bus.req = 3'b111;
        for (int k = 0; k < 13; k++) begin
            g = one << ((k / 4) % 3);
            d = (k == 0) ? 3'b000 : (one << (((k - 1) / 4) % 3));
            frame(g, d, 6);
        end
        step(1, 1);
        n_checks++; if (sb.size() != 0) $display("FAIL rr_sb_left: got %0d pending expected 0", sb.size()); else n_pass++;
    endtask

    task automatic test_owner_drop();
        do_reset();
        bus.req = 3'b010;
        for (int k = 0; k < 6; k++) frame(3'b010, (k == 0) ? 3'b000 : 3'b010, 5);
        step(3, 64);
        bus.req = 3'b000;
        repeat (4) step(4, 64);
        n_checks++; if (bus.grant !== 3'b010) $display("FAIL drop_mid_grant: got %b expected 010", bus.grant); else n_pass++;
        n_checks++; if (bus.color !== C1) $display("FAIL drop_mid_color: got %h expected %h", bus.color, C1); else n_pass++;
        frame(3'b000, 3'b010, 5);
        frame(3'b000, 3'b000, 5);
        n_checks++; if (bus.grant !== 3'b000) $display("FAIL drop_idle_grant: got %b expected 000", bus.grant); else n_pass++;
        n_checks++; if (bus.color !== BG) $display("FAIL drop_idle_color: got %h expected %h", bus.color, BG); else n_pass++;
        n_checks++; if (sb.size() != 0) $display("FAIL drop_sb_left: got %0d pending expected 0", sb.size()); else n_pass++;
    endtask

    task automatic test_held_origin();
        int s0;
        do_reset();
        bus.req = 3'b100;
        step(5, 5);
        n_checks++; if (bus.color !== BG) $display("FAIL held_pre_color: got %h expected %h", bus.color, BG); else n_pass++;
        s0 = n_starts;
        push_exp(3'b100, 3'b000);
        step(0, 0);
        n_checks++; if (bus.color !== C2) $display("FAIL held_post_color: got %h expected %h", bus.color, C2); else n_pass++;
        repeat (49) step(0, 0);
        step(1, 0);
        n_checks++; if ((n_starts - s0) != 1) $display("FAIL held_starts: got %0d expected 1", n_starts - s0); else n_pass++;
        n_checks++; if (bus.grant !== 3'b100) $display("FAIL held_grant: got %b expected 100", bus.grant); else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.req = 3'b010;
        frame(3'b010, 3'b000, 3);
        step(3, 70);
        n_checks++; if (bus.grant !== 3'b010) $display("FAIL rmid_pre_grant: got %b expected 010", bus.grant); else n_pass++;
        #2;
        resetn = 1'b0;
        #1;
        n_checks++; if (bus.grant !== 3'b000) $display("FAIL rmid_async_grant: got %b expected 000", bus.grant); else n_pass++;
        n_checks++; if (bus.color !== BG) $display("FAIL rmid_async_color: got %h expected %h", bus.color, BG); else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        sb.delete();
        exp_cnt   = 0;
        first_bnd = 1'b1;
        resetn    = 1'b1;
        bus.req   = 3'b011;
        step(9, 70);
        frame(3'b001, 3'b000, 3);
        frame(3'b001, 3'b001, 3);
        n_checks++; if (sb.size() != 0) $display("FAIL rmid_sb_left: got %0d pending expected 0", sb.size()); else n_pass++;
    endtask

    initial begin
        bus.req       = 3'b000;
        bus.src_color = {C2, C1, C0};
        bus.x         = 7'd9;
        bus.y         = 7'd9;
        fork
            monitor();
        join_none
        test_reset();
        test_late_req();
        test_round_robin();
        test_owner_drop();
        test_held_origin();
        test_reset_mid();
        step(2, 2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
